process_scheduler: RTL and testbench
====================================

Name: process_scheduler

Overview:
- Round-robin time-slice scheduler for the user programs that share the single program counter.
- Keeps a slot table with a ready bit and a saved resume address per slot (slot 0 is the OS and is never scheduled here).
- Counts retired instructions against a programmable quantum and preempts on expiry, program end, or yield.
- Hands the PC a (program, address) pair through a valid/ack dispatch handshake.

Parameters:
- N_SLOTS, 4, number of user program slots; slot ids are 1..N_SLOTS.
- ADDR_W, 32, width of program-relative addresses and the quantum.
- PROG_W, 3, width of program ids; must satisfy 2^PROG_W > N_SLOTS.

Ports:
- clock  in  1  single system clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- quantum_load  in  1  load quantum_in into the quantum register.
- quantum_in  in  ADDR_W  new quantum; 0 means cooperative, with no expiry.
- admit  in  1  mark slot admit_slot ready, with resume address admit_pc.
- admit_slot  in  PROG_W  slot to admit.
- admit_pc  in  ADDR_W  program-relative start address.
- instr_retired  in  1  one instruction of the running program completed this cycle.
- prog_end  in  1  running program executed its end instruction.
- yield  in  1  running program voluntarily gives up the CPU.
- resume_pc  in  ADDR_W  program-relative address at which the running program must resume.
- dispatch_valid  out  1  dispatch request is pending.
- dispatch_prog  out  PROG_W  program selected to run.
- dispatch_pc  out  ADDR_W  resume address of the selected program.
- dispatch_ack  in  1  PC has loaded the dispatch.
- preempt  out  1  one-cycle pulse when the running program is taken off the CPU.
- preempt_cause  out  2  valid with preempt: 01 expiry, 10 end, 11 yield.
- running_prog  out  PROG_W  program on the CPU; 0 when none.
- sched_idle  out  1  no slot is ready and nothing is running.

Behaviour:
- Reset (reset=0 at a clock edge) gives:
  - state IDLE, every ready bit 0, every saved address 0, quantum 0, instruction counter 0;
  - last-served pointer = N_SLOTS, so the first search starts at slot 1;
  - dispatch_valid=0, dispatch_prog=0, dispatch_pc=0, preempt=0, preempt_cause=0, running_prog=0, sched_idle=1.
- Reset mid-operation aborts everything, including a pending dispatch; no preempt pulse is produced.
- Admit: sets ready[admit_slot]=1 and saved[admit_slot]=admit_pc in any state.
  - Ignored for slot 0, for slots above N_SLOTS, and for the slot currently running.
  - Re-admitting a ready but non-running slot overwrites its saved address.
- quantum_load takes effect at the next edge; the running slice compares against the new value immediately.
- IDLE: sched_idle=1. If any ready bit is set (including one set this cycle), go to SELECT next cycle.
- SELECT (1 cycle): search slots ptr+1, ptr+2, … with wrap from N_SLOTS to 1. The first ready slot wins.
  - If a slot is found: latch it into dispatch_prog/dispatch_pc, set ptr to it, go to DISPATCH.
  - If none is found: go to IDLE.
- DISPATCH: dispatch_valid=1; prog and pc are held stable until an edge with dispatch_ack=1.
  - On that edge: running_prog = the selected slot, counter = 0, dispatch_valid=0, go to RUN.
- RUN:
  - Counter increments on instr_retired; it saturates at all ones.
  - Exit is taken when prog_end, or yield, or (quantum≠0 and counter+instr_retired ≥ quantum).
  - Exit priority when several hold: prog_end > yield > expiry.
  - On the exit edge, go to SAVE.
  - instr_retired on the exit edge is still counted, but the counter is discarded afterwards.
- SAVE (1 cycle): preempt=1 and preempt_cause is set.
  - If the cause is end: ready[running]=0.
  - Otherwise: saved[running]=resume_pc and the ready bit stays 1.
  - running_prog=0, then go to SELECT.
- With a single ready slot, expiry re-dispatches the same slot.
- Dispatch latency: at most 2 cycles from SAVE or IDLE to dispatch_valid (SELECT, then DISPATCH).
- prog_end, yield and instr_retired are ignored outside RUN.

Test Plan:
- Reset, then admit slot 2 with pc=0x10 → SELECT, then dispatch_valid=1, prog=2, pc=0x10. With ack → running_prog=2, sched_idle=0.
- Quantum=3, slots 1 (pc 0) and 3 (pc 5) ready. Run 3 instr_retired with resume_pc=0x7 → preempt with cause 01, saved[1]=7, next dispatch prog=3 pc=5. After slot 3 expires → dispatch prog=1 pc=7.
- Slot 4 running, prog_end and an expiry in the same cycle → cause 10, ready[4]=0. With no other slot ready → IDLE with sched_idle=1.
- Quantum=0 with 1000 instr_retired → no preempt. Yield → cause 11, and the same slot is re-dispatched with saved resume_pc.
- Hold dispatch_ack=0 for 5 cycles → dispatch_valid stays 1 with prog/pc constant; an admit of another slot meanwhile does not change them.
- Assert reset during RUN with 2 slots ready → next cycle all outputs are at reset values; a later admit of slot 1 dispatches prog=1. Admits of slot 0 and slot 5 are ignored.

Source files
------------

// File: rtl/process_scheduler_if.sv
// Dispatch channel between the process scheduler and the program counter.
// dispatch_valid rises with a stable (dispatch_prog, dispatch_pc) pair, which stays held until an edge with dispatch_ack=1 completes the transfer.
interface process_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int PROG_W = 3
);
    logic              dispatch_valid;
    logic [PROG_W-1:0] dispatch_prog;
    logic [ADDR_W-1:0] dispatch_pc;
    logic              dispatch_ack;

    modport master (output dispatch_valid, dispatch_prog, dispatch_pc, input dispatch_ack);
    modport slave  (input dispatch_valid, dispatch_prog, dispatch_pc, output dispatch_ack);
endinterface

// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler for user program slots 1..N_SLOTS sharing one PC.
// Preempts on quantum expiry, program end or yield and hands the next (prog, pc) pair out over the dispatch channel.
module process_scheduler #(
    parameter int N_SLOTS = 4,
    parameter int ADDR_W  = 32,
    parameter int PROG_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    quantum_load,
    input  logic [ADDR_W-1:0]       quantum_in,
    input  logic                    admit,
    input  logic [PROG_W-1:0]       admit_slot,
    input  logic [ADDR_W-1:0]       admit_pc,
    input  logic                    instr_retired,
    input  logic                    prog_end,
    input  logic                    yield,
    input  logic [ADDR_W-1:0]       resume_pc,
    process_scheduler_if.master     disp,
    output logic                    preempt,
    output logic [1:0]              preempt_cause,
    output logic [PROG_W-1:0]       running_prog,
    output logic                    sched_idle,
    output logic [2:0]              state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_DISPATCH = 3'd2,
        S_RUN      = 3'd3,
        S_SAVE     = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_EXPIRY = 2'b01;
    localparam logic [1:0] CAUSE_END    = 2'b10;
    localparam logic [1:0] CAUSE_YIELD  = 2'b11;

    state_t            state_q, state_d;
    logic [N_SLOTS:1]  ready_q, ready_d;
    logic [ADDR_W-1:0] saved_q [1:N_SLOTS];
    logic [ADDR_W-1:0] saved_d [1:N_SLOTS];
    logic [ADDR_W-1:0] quantum_q, quantum_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [PROG_W-1:0] ptr_q, ptr_d;
    logic [PROG_W-1:0] disp_prog_q, disp_prog_d;
    logic [ADDR_W-1:0] disp_pc_q, disp_pc_d;
    logic [PROG_W-1:0] running_q, running_d;
    logic [1:0]        cause_q, cause_d;

    logic              admit_ok;
    logic [ADDR_W:0]   count_sum;
    logic              expire;
    logic [1:0]        exit_cause;
    logic              found_hi, found_lo, sel_found;
    logic [PROG_W-1:0] sel_hi, sel_lo, sel_slot;
    logic [ADDR_W-1:0] sel_pc;

    // Admits of slot 0, out-of-range slots and the running slot are dropped.
    assign admit_ok   = admit && (admit_slot != '0) && (admit_slot <= PROG_W'(N_SLOTS))
                        && (admit_slot != running_q);
    assign count_sum  = {1'b0, count_q} + {{ADDR_W{1'b0}}, instr_retired};
    assign expire     = (quantum_q != '0) && (count_sum >= {1'b0, quantum_q});
    assign exit_cause = prog_end ? CAUSE_END : (yield ? CAUSE_YIELD : (expire ? CAUSE_EXPIRY : 2'b00));

    // Round-robin search: lowest ready slot above ptr, else lowest ready slot at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = N_SLOTS; j >= 1; j--) begin
            if (ready_q[j]) begin
                if (PROG_W'(j) > ptr_q) begin
                    found_hi = 1'b1;
                    sel_hi   = PROG_W'(j);
                end else begin
                    found_lo = 1'b1;
                    sel_lo   = PROG_W'(j);
                end
            end
        end
        sel_found = found_hi | found_lo;
        sel_slot  = found_hi ? sel_hi : sel_lo;
        sel_pc    = '0;
        for (int j = 1; j <= N_SLOTS; j++) begin
            if (sel_slot == PROG_W'(j)) sel_pc = saved_q[j];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ready_q     <= '0;
            quantum_q   <= '0;
            count_q     <= '0;
            ptr_q       <= PROG_W'(N_SLOTS);
            disp_prog_q <= '0;
            disp_pc_q   <= '0;
            running_q   <= '0;
            cause_q     <= '0;
            for (int j = 1; j <= N_SLOTS; j++) saved_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            quantum_q   <= quantum_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            disp_prog_q <= disp_prog_d;
            disp_pc_q   <= disp_pc_d;
            running_q   <= running_d;
            cause_q     <= cause_d;
            for (int j = 1; j <= N_SLOTS; j++) saved_q[j] <= saved_d[j];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if ((|ready_q) || admit_ok) state_d = S_SELECT;
            S_SELECT:   state_d = sel_found ? S_DISPATCH : S_IDLE;
            S_DISPATCH: if (disp.dispatch_ack) state_d = S_RUN;
            S_RUN:      if (exit_cause != 2'b00) state_d = S_SAVE;
            S_SAVE:     state_d = S_SELECT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d     = ready_q;
        quantum_d   = quantum_load ? quantum_in : quantum_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        disp_prog_d = disp_prog_q;
        disp_pc_d   = disp_pc_q;
        running_d   = running_q;
        cause_d     = cause_q;
        for (int j = 1; j <= N_SLOTS; j++) begin
            saved_d[j] = saved_q[j];
            if (admit_ok && (admit_slot == PROG_W'(j))) begin
                ready_d[j] = 1'b1;
                saved_d[j] = admit_pc;
            end
        end
        case (state_q)
            S_SELECT: begin
                if (sel_found) begin
                    disp_prog_d = sel_slot;
                    disp_pc_d   = sel_pc;
                    ptr_d       = sel_slot;
                end
            end
            S_DISPATCH: begin
                if (disp.dispatch_ack) begin
                    running_d = disp_prog_q;
                    count_d   = '0;
                end
            end
            S_RUN: begin
                count_d = count_sum[ADDR_W] ? '1 : count_sum[ADDR_W-1:0];
                if (exit_cause != 2'b00) cause_d = exit_cause;
            end
            S_SAVE: begin
                for (int j = 1; j <= N_SLOTS; j++) begin
                    if (running_q == PROG_W'(j)) begin
                        if (cause_q == CAUSE_END) ready_d[j] = 1'b0;
                        else                      saved_d[j] = resume_pc;
                    end
                end
                running_d = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        disp.dispatch_valid = (state_q == S_DISPATCH);
        disp.dispatch_prog  = disp_prog_q;
        disp.dispatch_pc    = disp_pc_q;
        preempt             = (state_q == S_SAVE);
        preempt_cause       = (state_q == S_SAVE) ? cause_q : 2'b00;
        running_prog        = running_q;
        sched_idle          = (state_q == S_IDLE);
        state_dbg           = state_q;
    end
endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios plus randomized slices scored against a slot-table model.
module tb_process_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          quantum_load = 1'b0;
  logic [AW-1:0] quantum_in = '0;
  logic          admit = 1'b0;
  logic [PW-1:0] admit_slot = '0;
  logic [AW-1:0] admit_pc = '0;
  logic          instr_retired = 1'b0;
  logic          prog_end = 1'b0;
  logic          yield = 1'b0;
  logic [AW-1:0] resume_pc = '0;
  logic          preempt;
  logic [1:0]    preempt_cause;
  logic [PW-1:0] running_prog;
  logic          sched_idle;
  logic [2:0]    state_dbg;

  process_scheduler_if #(.ADDR_W(AW), .PROG_W(PW)) disp_if ();

  process_scheduler #(.N_SLOTS(N), .ADDR_W(AW), .PROG_W(PW)) dut (
    .clock(clock), .reset(reset),
    .quantum_load(quantum_load), .quantum_in(quantum_in),
    .admit(admit), .admit_slot(admit_slot), .admit_pc(admit_pc),
    .instr_retired(instr_retired), .prog_end(prog_end), .yield(yield),
    .resume_pc(resume_pc), .disp(disp_if.master),
    .preempt(preempt), .preempt_cause(preempt_cause),
    .running_prog(running_prog), .sched_idle(sched_idle), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: slot table, round-robin pointer, quantum and slice count
  bit            m_ready [1:N];
  logic [AW-1:0] m_saved [1:N];
  int            m_ptr;
  int            m_running;
  logic [AW-1:0] m_q;
  longint        m_cnt;
  logic [PW+AW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N + 1;
      if (m_ready[s]) return s;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 1; s <= N; s++) begin
      m_ready[s] = 1'b0;
      m_saved[s] = '0;
    end
    m_ptr = N;
    m_running = 0;
    m_q = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic clear_pulses();
    admit = 1'b0;
    quantum_load = 1'b0;
    instr_retired = 1'b0;
    prog_end = 1'b0;
    yield = 1'b0;
    disp_if.dispatch_ack = 1'b0;
  endtask

  task automatic set_admit(input int slot, input logic [AW-1:0] pc);
    admit = 1'b1;
    admit_slot = PW'(slot);
    admit_pc = pc;
    if (slot >= 1 && slot <= N && slot != m_running) begin
      m_ready[slot] = 1'b1;
      m_saved[slot] = pc;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", disp_if.dispatch_valid, 0);
    chk("rst_prog", disp_if.dispatch_prog, 0);
    chk("rst_pc", disp_if.dispatch_pc, 0);
    chk("rst_preempt", preempt, 0);
    chk("rst_cause", preempt_cause, 0);
    chk("rst_running", running_prog, 0);
    chk("rst_idle", sched_idle, 1);
  endtask

  task automatic do_reset();
    clear_pulses();
    reset = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_dispatch();
    int n;
    n = 0;
    while (!disp_if.dispatch_valid && n < 8) begin
      tick();
      n++;
    end
    if (!disp_if.dispatch_valid) begin
      chk("dispatch_timeout", 0, 1);
      report();
    end
    chk("dispatch_latency", (n <= 2), 1);
  endtask

  task automatic next_dispatch(input int hold, input bit admit_during, output bit got);
    int s;
    logic [PW+AW-1:0] e;
    clear_pulses();
    s = pick();
    got = 1'b0;
    if (s == 0) begin
      tick();
      tick();
      chk("idle_flag", sched_idle, 1);
      chk("idle_no_valid", disp_if.dispatch_valid, 0);
      return;
    end
    exp_q.push_back({PW'(s), m_saved[s]});
    wait_dispatch();
    e = exp_q.pop_front();
    chk("disp_prog", disp_if.dispatch_prog, e[PW+AW-1:AW]);
    chk("disp_pc", disp_if.dispatch_pc, e[AW-1:0]);
    chk("disp_not_running", running_prog, 0);
    m_ptr = s;
    for (int h = 0; h < hold; h++) begin
      if (admit_during) set_admit($urandom_range(0, 7), $urandom);
      tick();
      admit = 1'b0;
      chk("hold_valid", disp_if.dispatch_valid, 1);
      chk("hold_prog", disp_if.dispatch_prog, e[PW+AW-1:AW]);
      chk("hold_pc", disp_if.dispatch_pc, e[AW-1:0]);
    end
    disp_if.dispatch_ack = 1'b1;
    tick();
    disp_if.dispatch_ack = 1'b0;
    chk("ack_running", running_prog, s);
    chk("ack_valid_low", disp_if.dispatch_valid, 0);
    chk("ack_busy", sched_idle, 0);
    m_running = s;
    m_cnt = 0;
    got = 1'b1;
  endtask

  // mode 0: retire every cycle; 1: random; 2: end lands on the expiry cycle; 3: retire until a final yield
  task automatic run_slice(input int mode, input int max_cyc, input logic [AW-1:0] rpc);
    for (int c = 0; c < 5000; c++) begin
      logic ir, pe, yl;
      logic [AW-1:0] rp;
      longint sum;
      int cause;
      ir = 1'b1; pe = 1'b0; yl = 1'b0; rp = rpc;
      if (mode == 1) begin
        int r;
        ir = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 15);
        pe = (r == 0);
        yl = (r == 1) || (c == max_cyc - 1);
        rp = $urandom;
      end else if (mode == 2) begin
        pe = (m_q != 0) && (m_cnt + 1 >= longint'(m_q));
      end else if (mode == 3) begin
        yl = (c == max_cyc - 1);
      end
      sum = m_cnt + longint'(ir);
      cause = pe ? 2 : (yl ? 3 : ((m_q != 0 && sum >= longint'(m_q)) ? 1 : 0));
      instr_retired = ir; prog_end = pe; yield = yl; resume_pc = rp;
      if (mode == 1) begin
        if ($urandom_range(0, 3) == 0) set_admit($urandom_range(0, 7), $urandom);
        if ($urandom_range(0, 15) == 0) begin
          quantum_load = 1'b1;
          quantum_in = AW'($urandom_range(0, 6));
        end
      end
      tick();
      if (quantum_load) m_q = quantum_in;
      clear_pulses();
      m_cnt = sum;
      if (cause != 0) begin
        chk("preempt", preempt, 1);
        chk("preempt_cause", preempt_cause, cause);
        if (cause == 2) m_ready[m_running] = 1'b0;
        else            m_saved[m_running] = rp;
        m_running = 0;
        return;
      end
      chk("no_preempt", preempt, 0);
    end
    chk("slice_timeout", 0, 1);
    report();
  endtask

  initial begin
    bit got;
    model_reset();
    do_reset();

    // first admit reaches dispatch through SELECT
    set_admit(2, 'h10);
    tick();
    admit = 1'b0;
    chk("t1_select_no_valid", disp_if.dispatch_valid, 0);
    chk("t1_left_idle", sched_idle, 0);
    next_dispatch(0, 0, got);

    // quantum 3 alternation between slots 1 and 3
    do_reset();
    quantum_load = 1'b1; quantum_in = 3; m_q = 3;
    set_admit(1, 'h0);
    tick();
    quantum_load = 1'b0;
    set_admit(3, 'h5);
    tick();
    admit = 1'b0;
    next_dispatch(0, 0, got);
    run_slice(0, 0, 'h7);
    next_dispatch(0, 0, got);
    run_slice(0, 0, 'h9);
    next_dispatch(0, 0, got);
    chk("t2_back_to_1", running_prog, 1);

    // end and expiry together on slot 4, nothing left ready
    do_reset();
    quantum_load = 1'b1; quantum_in = 2; m_q = 2;
    set_admit(4, 'h40);
    tick();
    next_dispatch(0, 0, got);
    run_slice(2, 0, 'h41);
    next_dispatch(0, 0, got);
    chk("t3_went_idle", got, 0);

    // cooperative slice, then yield and re-dispatch of the same slot
    do_reset();
    set_admit(2, 'h20);
    tick();
    next_dispatch(0, 0, got);
    run_slice(3, 1000, 'h123);
    next_dispatch(0, 0, got);

    // dispatch held without ack while other admits arrive
    do_reset();
    set_admit(1, 'h30);
    tick();
    next_dispatch(5, 1, got);

    // reset during RUN, ignored admits, then a fresh dispatch
    do_reset();
    set_admit(1, 'h50);
    tick();
    set_admit(2, 'h60);
    tick();
    next_dispatch(0, 0, got);
    instr_retired = 1'b1;
    tick(); tick(); tick();
    clear_pulses();
    reset = 1'b0;
    tick();
    check_reset_outputs();
    reset = 1'b1;
    model_reset();
    set_admit(0, 'h99);
    tick();
    set_admit(5, 'h98);
    tick();
    admit = 1'b0;
    tick(); tick();
    chk("t6_ignored_idle", sched_idle, 1);
    chk("t6_ignored_valid", disp_if.dispatch_valid, 0);
    set_admit(1, 'h44);
    tick();
    next_dispatch(0, 0, got);

    // randomized slices
    do_reset();
    quantum_load = 1'b1;
    quantum_in = AW'($urandom_range(0, 6));
    m_q = quantum_in;
    set_admit($urandom_range(1, N), $urandom);
    tick();
    clear_pulses();
    for (int it = 0; it < 60; it++) begin
      next_dispatch($urandom_range(0, 3), 1, got);
      if (!got) begin
        set_admit($urandom_range(1, N), $urandom);
        tick();
        admit = 1'b0;
      end else begin
        run_slice(1, $urandom_range(5, 40), '0);
      end
    end

    report();
  end
endmodule
